// File: rtl/mult_unit_x.sv
// Iterative signed shift-add multiplier for the execute stage.
// Freezes the front of the pipeline while a MULT is in flight.
module mult_unit_x #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_X,
    input  logic                  flush_X,
    input  logic [DATA_W-1:0]     rs_data_X,
    input  logic [DATA_W-1:0]     rt_data_X,
    input  logic [REG_ADDR_W-1:0] dest_reg_X,
    output logic                  stall_mult,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_W-1:0]     result_lo,
    output logic [DATA_W-1:0]     result_hi,
    output logic [REG_ADDR_W-1:0] result_reg
);

    localparam int N  = DATA_W / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         mcand;
    logic [PW-1:0]         acc;
    logic [PW-1:0]         acc_nxt;
    logic [PW-1:0]         prod;
    logic [DATA_W-1:0]     mplier;
    logic [DATA_W-1:0]     rs_abs;
    logic [DATA_W-1:0]     rt_abs;
    logic                  sign;
    logic [REG_ADDR_W-1:0] dest;
    logic                  go;

    // Magnitudes fit DATA_W bits unsigned, so the most-negative value is exact.
    assign rs_abs = rs_data_X[DATA_W-1] ? (~rs_data_X + 1'b1) : rs_data_X;
    assign rt_abs = rt_data_X[DATA_W-1] ? (~rt_data_X + 1'b1) : rt_data_X;

    assign go = start_X && !flush_X;

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i])
                acc_nxt = acc_nxt + (mcand << i);
        end
    end

    assign prod = sign ? (~acc_nxt + 1'b1) : acc_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mcand      <= '0;
            acc        <= '0;
            mplier     <= '0;
            sign       <= 1'b0;
            dest       <= '0;
            result_lo  <= '0;
            result_hi  <= '0;
            result_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{DATA_W{1'b0}}, rs_abs};
                        mplier <= rt_abs;
                        sign   <= rs_data_X[DATA_W-1] ^ rt_data_X[DATA_W-1];
                        dest   <= dest_reg_X;
                    end
                end
                BUSY: begin
                    if (flush_X) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CW'(N - 1)) begin
                            state      <= DONE;
                            cnt        <= '0;
                            result_hi  <= prod[PW-1:DATA_W];
                            result_lo  <= prod[DATA_W-1:0];
                            result_reg <= dest;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && !flush_X;
    assign stall_mult   = rst && !flush_X &&
                          ((state == IDLE && start_X) || state == BUSY);

endmodule

// File: tb/tb_mult_unit_x.sv
// Scoreboard bench for mult_unit_x.
// Expected products come from a 64-bit signed reference multiply.
module tb_mult_unit_x;

    localparam int DW = 32;
    localparam int N  = 32;

    typedef struct packed {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [4:0]    rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_X = 1'b0;
    logic          flush_X = 1'b0;
    logic [DW-1:0] rs_data_X = '0;
    logic [DW-1:0] rt_data_X = '0;
    logic [4:0]    dest_reg_X = '0;
    logic          stall_mult;
    logic          busy;
    logic          result_valid;
    logic [DW-1:0] result_lo;
    logic [DW-1:0] result_hi;
    logic [4:0]    result_reg;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     last_valid_cyc = 0;
    logic [DW-1:0] last_hi = '0;
    logic [DW-1:0] last_lo = '0;

    mult_unit_x dut (
        .clk          (clk),
        .rst          (rst),
        .start_X      (start_X),
        .flush_X      (flush_X),
        .rs_data_X    (rs_data_X),
        .rt_data_X    (rt_data_X),
        .dest_reg_X   (dest_reg_X),
        .stall_mult   (stall_mult),
        .busy         (busy),
        .result_valid (result_valid),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .result_reg   (result_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_mul(input logic [DW-1:0] a,
                                     input logic [DW-1:0] b,
                                     input logic [4:0] d);
        logic signed [63:0] sa;
        logic signed [63:0] sb_;
        logic signed [63:0] p;
        exp_t e;
        sa   = {{32{a[DW-1]}}, a};
        sb_  = {{32{b[DW-1]}}, b};
        p    = sa * sb_;
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.rd = d;
        return e;
    endfunction

    // Monitor: pop and compare on each product pulse.
    always @(posedge clk) begin
        #1;
        if (result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(result_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_hi", 64'(result_hi), 64'(e.hi));
                chk("result_lo", 64'(result_lo), 64'(e.lo));
                chk("result_reg", 64'(result_reg), 64'(e.rd));
                last_hi = e.hi;
                last_lo = e.lo;
            end
            last_valid_cyc = cyc;
        end
    end

    // Drive one MULT from an IDLE negedge; return stall count and latency.
    task automatic run_mult(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [4:0] d, input bit toggle,
                            input bit drop, output int stalls,
                            output int lat);
        bit seen;
        rs_data_X  = a;
        rt_data_X  = b;
        dest_reg_X = d;
        start_X    = 1'b1;
        sb.push_back(ref_mul(a, b, d));
        stalls = 0;
        lat    = 0;
        seen   = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (result_valid) begin
                seen = 1;
                break;
            end
            if (stall_mult) stalls++;
            @(negedge clk);
            lat++;
            if (toggle) begin
                rs_data_X = $urandom;
                rt_data_X = $urandom;
            end
        end
        if (!seen) chk("timeout", 64'd0, 64'd1);
        if (drop) start_X = 1'b0;
    endtask

    int st;
    int lt;
    int c1;

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall_mult), 64'd0);
        chk("rst_lo", 64'(result_lo), 64'd0);
        chk("rst_reg", 64'(result_reg), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_mult(32'd7, 32'd6, 5'd9, 0, 1, st, lt);
        chk("stall_cycles", 64'(st), 64'(N + 1));
        chk("latency", 64'(lt), 64'(N + 1));
        @(negedge clk);
        chk("idle_after", 64'(busy), 64'd0);

        run_mult(-32'sd3, 32'd5, 5'd3, 0, 1, st, lt);
        @(negedge clk);
        run_mult(32'h8000_0000, 32'h8000_0000, 5'd31, 0, 1, st, lt);
        @(negedge clk);
        run_mult(32'd0, 32'hFFFF_FFFF, 5'd1, 0, 1, st, lt);
        @(negedge clk);
        run_mult(32'h1234_5678, 32'h8765_4321, 5'd17, 1, 1, st, lt);
        @(negedge clk);
        run_mult(32'h7FFF_FFFF, 32'h8000_0000, 5'd4, 0, 1, st, lt);
        @(negedge clk);

        // Flush at BUSY cycle 10: no product, outputs retained.
        rs_data_X = 32'd11;
        rt_data_X = 32'd13;
        start_X   = 1'b1;
        repeat (10) @(negedge clk);
        flush_X = 1'b1;
        #1;
        chk("flush_stall", 64'(stall_mult), 64'd0);
        @(negedge clk);
        chk("flush_idle", 64'(busy), 64'd0);
        start_X = 1'b0;
        flush_X = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_keep_hi", 64'(result_hi), 64'(last_hi));
        chk("flush_keep_lo", 64'(result_lo), 64'(last_lo));

        // Async reset mid-BUSY.
        start_X = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_stall", 64'(stall_mult), 64'd0);
        chk("arst_hi", 64'(result_hi), 64'd0);
        chk("arst_lo", 64'(result_lo), 64'd0);
        chk("arst_reg", 64'(result_reg), 64'd0);
        start_X = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_mult(-32'sd100, -32'sd250, 5'd12, 0, 1, st, lt);
        @(negedge clk);

        // Back-to-back with start_X held high.
        run_mult(32'd1000, -32'sd7, 5'd5, 0, 0, st, lt);
        c1 = cyc;
        rs_data_X  = 32'hDEAD_BEEF;
        rt_data_X  = 32'd3;
        dest_reg_X = 5'd6;
        sb.push_back(ref_mul(32'hDEAD_BEEF, 32'd3, 5'd6));
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            #1;
            if (result_valid) break;
            @(negedge clk);
        end
        chk("b2b_spacing", 64'(cyc - c1), 64'(N + 2));
        start_X = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
